// File: rtl/alu_issue_decoder.sv
// Decode/issue stage for the RV32I ALU.
// Decodes OP, OP-IMM, LUI and AUIPC into operand A/B and a 4-bit ALU select.
// Results are held in a single-entry output register with valid/ready flow
// control. Flush takes priority over every other action. A saturating counter
// tracks how many legal instructions have been accepted.
module alu_issue_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instruction,
    input  logic [31:0]      pc,
    output logic [4:0]       rs1_addr,
    output logic [4:0]       rs2_addr,
    input  logic [31:0]      rs1_value,
    input  logic [31:0]      rs2_value,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      Register1_value,
    output logic [31:0]      Register2_value,
    output logic [3:0]       ALU_sel,
    output logic [4:0]       rd_addr,
    output logic             rd_write_en,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] issued_count
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] SEL_ADD  = 4'd0;
    localparam logic [3:0] SEL_SUB  = 4'd1;
    localparam logic [3:0] SEL_SLL  = 4'd2;
    localparam logic [3:0] SEL_SLT  = 4'd3;
    localparam logic [3:0] SEL_SLTU = 4'd4;
    localparam logic [3:0] SEL_XOR  = 4'd5;
    localparam logic [3:0] SEL_SRL  = 4'd6;
    localparam logic [3:0] SEL_SRA  = 4'd7;
    localparam logic [3:0] SEL_OR   = 4'd8;
    localparam logic [3:0] SEL_AND  = 4'd9;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd_field;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] shamt_imm;
    logic [31:0] shamt_reg;

    logic [3:0]  f3_sel;
    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic [3:0]  dec_sel;
    logic        dec_illegal;
    logic        accept;

    assign opcode    = instruction[6:0];
    assign funct3    = instruction[14:12];
    assign funct7    = instruction[31:25];
    assign rd_field  = instruction[11:7];
    assign imm_i     = {{20{instruction[31]}}, instruction[31:20]};
    assign imm_u     = {instruction[31:12], 12'b0};
    assign shamt_imm = {27'b0, instruction[24:20]};
    assign shamt_reg = {27'b0, rs2_value[4:0]};

    assign rs1_addr = instruction[19:15];
    assign rs2_addr = instruction[24:20];

    // The single output slot can take a new instruction when empty or draining.
    assign instr_ready = !rst && (!out_valid || out_ready);
    assign accept      = instr_valid && instr_ready && !flush;

    // Base funct3 -> ALU select mapping shared by OP and OP-IMM.
    always_comb begin
        f3_sel = SEL_ADD;
        case (funct3)
            3'b000:  f3_sel = SEL_ADD;
            3'b001:  f3_sel = SEL_SLL;
            3'b010:  f3_sel = SEL_SLT;
            3'b011:  f3_sel = SEL_SLTU;
            3'b100:  f3_sel = SEL_XOR;
            3'b101:  f3_sel = SEL_SRL;
            3'b110:  f3_sel = SEL_OR;
            default: f3_sel = SEL_AND;
        endcase
    end

    // Instruction decode into operands, select code and legality.
    always_comb begin
        dec_a       = 32'b0;
        dec_b       = 32'b0;
        dec_sel     = SEL_ADD;
        dec_illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_a = rs1_value;
                if (funct7 == F7_BASE) begin
                    dec_sel = f3_sel;
                    // Shifts only use the low five bits of rs2 as the amount.
                    dec_b   = (funct3 == 3'b001 || funct3 == 3'b101) ? shamt_reg : rs2_value;
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_sel = SEL_SUB;
                    dec_b   = rs2_value;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_sel = SEL_SRA;
                    dec_b   = shamt_reg;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec_a = rs1_value;
                case (funct3)
                    3'b001: begin
                        dec_sel     = SEL_SLL;
                        dec_b       = shamt_imm;
                        dec_illegal = (funct7 != F7_BASE);
                    end
                    3'b101: begin
                        dec_b = shamt_imm;
                        if (funct7 == F7_BASE) begin
                            dec_sel = SEL_SRL;
                        end else if (funct7 == F7_ALT) begin
                            dec_sel = SEL_SRA;
                        end else begin
                            dec_illegal = 1'b1;
                        end
                    end
                    default: begin
                        dec_sel = f3_sel;
                        dec_b   = imm_i;
                    end
                endcase
            end
            OPC_LUI: begin
                dec_b = imm_u;
            end
            OPC_AUIPC: begin
                dec_a = pc;
                dec_b = imm_u;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
        // Illegal instructions present a neutral, all-zero operation.
        if (dec_illegal) begin
            dec_a   = 32'b0;
            dec_b   = 32'b0;
            dec_sel = SEL_ADD;
        end
    end

    // Output slot: flush clears, accept loads, drain empties, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid       <= 1'b0;
            Register1_value <= 32'b0;
            Register2_value <= 32'b0;
            ALU_sel         <= 4'b0;
            rd_addr         <= 5'b0;
            rd_write_en     <= 1'b0;
            illegal_instr   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid       <= 1'b1;
            Register1_value <= dec_a;
            Register2_value <= dec_b;
            ALU_sel         <= dec_sel;
            rd_addr         <= rd_field;
            rd_write_en     <= !dec_illegal && (rd_field != 5'd0);
            illegal_instr   <= dec_illegal;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating count of accepted legal instructions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued_count <= '0;
        end else if (accept && !dec_illegal && (issued_count != {CNT_W{1'b1}})) begin
            issued_count <= issued_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Directed bench for alu_issue_decoder with a scoreboard of expected outputs.
module tb_alu_issue_decoder;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Register1_value;
    logic [31:0] Register2_value;
    logic [3:0]  ALU_sel;
    logic [4:0]  rd_addr;
    logic        rd_write_en;
    logic        illegal_instr;
    logic [15:0] issued_count;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   exp_cnt = 0;

    alu_issue_decoder #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .pc(pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_value(rs1_value), .rs2_value(rs2_value),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .Register1_value(Register1_value), .Register2_value(Register2_value),
        .ALU_sel(ALU_sel), .rd_addr(rd_addr), .rd_write_en(rd_write_en),
        .illegal_instr(illegal_instr), .issued_count(issued_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] sel, input logic [4:0] rd,
                                input logic we, input logic ill);
        exp_t e;
        e.a = a; e.b = b; e.sel = sel; e.rd = rd; e.we = we; e.ill = ill;
        return e;
    endfunction

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_fields(input string tag, input exp_t e);
        cmp({tag, ".A"},   Register1_value, e.a);
        cmp({tag, ".B"},   Register2_value, e.b);
        cmp({tag, ".sel"}, {28'b0, ALU_sel}, {28'b0, e.sel});
        cmp({tag, ".rd"},  {27'b0, rd_addr}, {27'b0, e.rd});
        cmp({tag, ".we"},  {31'b0, rd_write_en}, {31'b0, e.we});
        cmp({tag, ".ill"}, {31'b0, illegal_instr}, {31'b0, e.ill});
        cmp({tag, ".cnt"}, {16'b0, issued_count}, exp_cnt);
    endtask

    // Pops the oldest expectation and compares it against the output slot.
    task automatic check_out(input string tag);
        exp_t e;
        cmp({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s scoreboard got=empty exp=entry", tag);
        end else begin
            e = sb.pop_front();
            check_fields(tag, e);
            $display("[TB] %s A=%h B=%h sel=%0d rd=%0d we=%0b ill=%0b cnt=%0d",
                     tag, Register1_value, Register2_value, ALU_sel, rd_addr,
                     rd_write_en, illegal_instr, issued_count);
        end
    endtask

    // Presents one instruction, waits (bounded) for acceptance, then drops valid.
    task automatic drive(input string tag, input logic [31:0] ins, input logic [31:0] pc_v,
                         input logic [31:0] r1, input logic [31:0] r2, input exp_t e);
        bit ok;
        instruction = ins; pc = pc_v; rs1_value = r1; rs2_value = r2;
        instr_valid = 1'b1;
        #1;
        cmp({tag, ".rs1_addr"}, {27'b0, rs1_addr}, {27'b0, ins[19:15]});
        cmp({tag, ".rs2_addr"}, {27'b0, rs2_addr}, {27'b0, ins[24:20]});
        sb.push_back(e);
        if (!e.ill) exp_cnt++;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (instr_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $error("FAIL %s accept_timeout got=no_ready exp=ready", tag);
        end
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    exp_t e_xor;
    exp_t e_slt;

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instruction = 32'b0; pc = 32'b0;
        rs1_value = 32'b0; rs2_value = 32'b0; flush = 1'b0; out_ready = 1'b1;
        idle(2);
        cmp("reset.valid", {31'b0, out_valid}, 32'd0);
        cmp("reset.ready", {31'b0, instr_ready}, 32'd0);
        check_fields("reset", mk(32'h0, 32'h0, 4'd0, 5'd0, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        // Main decode sequence with out_ready held high.
        drive("addi", 32'hFFF08293, 32'h0, 32'd10, 32'h0, mk(32'd10, 32'hFFFFFFFF, 4'd0, 5'd5, 1'b1, 1'b0));
        check_out("addi");
        drive("srai", 32'h40415193, 32'h0, 32'h80, 32'h0, mk(32'h80, 32'd4, 4'd7, 5'd3, 1'b1, 1'b0));
        check_out("srai");
        drive("sub", 32'h403100B3, 32'h0, 32'd7, 32'hFFFFFF25, mk(32'd7, 32'hFFFFFF25, 4'd1, 5'd1, 1'b1, 1'b0));
        check_out("sub");
        drive("sra", 32'h403150B3, 32'h0, 32'd7, 32'hFFFFFF25, mk(32'd7, 32'd5, 4'd7, 5'd1, 1'b1, 1'b0));
        check_out("sra");
        drive("lui", 32'h123453B7, 32'h0, 32'h55, 32'h66, mk(32'h0, 32'h12345000, 4'd0, 5'd7, 1'b1, 1'b0));
        check_out("lui");
        drive("auipc", 32'h12345397, 32'h100, 32'h55, 32'h66, mk(32'h100, 32'h12345000, 4'd0, 5'd7, 1'b1, 1'b0));
        check_out("auipc");
        drive("and", 32'h0062F233, 32'h0, 32'hF0F0_1234, 32'h0FF0_00FF, mk(32'hF0F0_1234, 32'h0FF0_00FF, 4'd9, 5'd4, 1'b1, 1'b0));
        check_out("and");
        drive("ecall", 32'h00000073, 32'h0, 32'h11, 32'h22, mk(32'h0, 32'h0, 4'd0, 5'd0, 1'b0, 1'b1));
        check_out("ecall");
        drive("add_f7bad", 32'h023100B3, 32'h0, 32'h11, 32'h22, mk(32'h0, 32'h0, 4'd0, 5'd1, 1'b0, 1'b1));
        check_out("add_f7bad");
        drive("slli_bad", 32'h40311093, 32'h0, 32'h11, 32'h22, mk(32'h0, 32'h0, 4'd0, 5'd1, 1'b0, 1'b1));
        check_out("slli_bad");
        drive("addi_x0", 32'h00000013, 32'h0, 32'd3, 32'h0, mk(32'd3, 32'h0, 4'd0, 5'd0, 1'b0, 1'b0));
        check_out("addi_x0");
        idle(1);
        cmp("drain.valid", {31'b0, out_valid}, 32'd0);

        // Stall: output held while out_ready is low, then back-to-back transfer.
        out_ready = 1'b0;
        e_xor = mk(32'h0000_FF00, 32'h0F0F_0F0F, 4'd5, 5'd2, 1'b1, 1'b0);
        drive("xor", 32'h0041C133, 32'h0, 32'h0000_FF00, 32'h0F0F_0F0F, e_xor);
        check_out("xor");
        e_slt = mk(32'hFFFF_FFFE, 32'd1, 4'd3, 5'd8, 1'b1, 1'b0);
        instruction = 32'h00A4A433; rs1_value = 32'hFFFF_FFFE; rs2_value = 32'd1;
        instr_valid = 1'b1;
        sb.push_back(e_slt);
        exp_cnt++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            cmp("stall.ready", {31'b0, instr_ready}, 32'd0);
            cmp("stall.valid", {31'b0, out_valid}, 32'd1);
            exp_cnt--;
            check_fields("stall", e_xor);
            exp_cnt++;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        check_out("b2b_slt");

        // Flush with a held output and an incoming instruction.
        out_ready = 1'b0;
        instruction = 32'hFFF08293; rs1_value = 32'd1;
        instr_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        cmp("flush.valid", {31'b0, out_valid}, 32'd0);
        cmp("flush.cnt", {16'b0, issued_count}, exp_cnt);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        cmp("flush2.valid", {31'b0, out_valid}, 32'd0);
        cmp("flush2.cnt", {16'b0, issued_count}, exp_cnt);
        flush = 1'b0;
        instr_valid = 1'b0;
        idle(1);

        // Asynchronous reset in the middle of a stall.
        out_ready = 1'b0;
        drive("pre_rst", 32'h00000013, 32'h0, 32'd9, 32'h0, mk(32'd9, 32'h0, 4'd0, 5'd0, 1'b0, 1'b0));
        check_out("pre_rst");
        #2;
        rst = 1'b1;
        #1;
        exp_cnt = 0;
        cmp("rst_mid.valid", {31'b0, out_valid}, 32'd0);
        cmp("rst_mid.ready", {31'b0, instr_ready}, 32'd0);
        check_fields("rst_mid", mk(32'h0, 32'h0, 4'd0, 5'd0, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;

        // Saturation: fill the counter to all-ones, then accept one more.
        instruction = 32'hFFF08293; rs1_value = 32'd1; instr_valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            @(posedge clk);
        end
        #1;
        cmp("sat_fill.cnt", {16'b0, issued_count}, 32'h0000FFFF);
        @(posedge clk);
        #1;
        cmp("sat_hold.cnt", {16'b0, issued_count}, 32'h0000FFFF);
        cmp("sat_hold.valid", {31'b0, out_valid}, 32'd1);
        instr_valid = 1'b0;
        $display("[TB] saturation cnt=%0d", issued_count);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
